// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable clock divider. Each channel produces a divided
// square wave and a one-cycle tick strobe per period. Both are intended as
// clock enables and timer strobes, not as routed clocks. Each channel can run
// in periodic mode or in one-shot mode. A global sync strobe restarts all
// channels in phase.
//
// Parameters:
//   CHANNELS     number of independent channels (1..16)
//   WIDTH        counter / divisor width in bits
//   DEFAULT_DIV  divisor loaded into every channel at reset
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         per-channel count enable (level)
//   load       single-cycle strobe: write load_div/load_mode into load_ch
//   load_ch    target channel for load (out-of-range loads are ignored)
//   load_div   new divisor (0 behaves as 1)
//   load_mode  0 = periodic, 1 = one-shot
//   sync       single-cycle strobe: restart every channel at cnt = 0
//   div_out    divided square outputs, registered
//   tick       one-cycle strobe per period, registered
//   armed      channel may count (one-shot not yet expired)
// ----------------------------------------------------------------------------
module clk_div_multi #(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 28,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                load,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load_div,
    input  logic                load_mode,
    input  logic                sync,
    output logic [CHANNELS-1:0] div_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] armed
);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [WIDTH-1:0]    div_eff [CHANNELS];
    logic [CHANNELS-1:0] mode_q,    mode_d;
    logic [CHANNELS-1:0] armed_q,   armed_d;
    logic [CHANNELS-1:0] div_out_q, div_out_d;
    logic [CHANNELS-1:0] tick_q,    tick_d;
    logic                load_hit;
    logic                load_out_init;

    // A stored divisor of 0 behaves as 1.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            div_eff[i] = (div_q[i] == '0) ? WIDTH'(1) : div_q[i];
        end
    end

    assign load_hit = load && (int'(load_ch) < CHANNELS);

    // Output level at cnt = 0 for the incoming divisor: high only when D == 1,
    // which holds for load_div of 0 or 1.
    assign load_out_init = (load_div <= WIDTH'(1));

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value before any
        // branch, so no path leaves one unassigned and no latch is inferred.
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            mode_d[i]    = mode_q[i];
            armed_d[i]   = armed_q[i];
            div_out_d[i] = div_out_q[i];
            tick_d[i]    = 1'b0;

            if (en[i] && armed_q[i]) begin
                if (cnt_q[i] == div_eff[i] - WIDTH'(1)) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    // One-shot channels disarm on the wrap that raises tick.
                    if (mode_q[i]) begin
                        armed_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
                div_out_d[i] = (cnt_d[i] >= (div_eff[i] >> 1));
            end

            // sync overrides a coincident wrap: no tick, and a one-shot
            // channel that would have expired this cycle stays armed.
            if (sync) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b0;
                armed_d[i]   = armed_q[i];
                div_out_d[i] = ((div_eff[i] >> 1) == '0);
            end

            // load is applied last so it also wins over sync for its channel.
            if (load_hit && (int'(load_ch) == i)) begin
                div_d[i]     = load_div;
                mode_d[i]    = load_mode;
                cnt_d[i]     = '0;
                armed_d[i]   = 1'b1;
                tick_d[i]    = 1'b0;
                div_out_d[i] = load_out_init;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are small register files, not RAM,
            // so they are reset explicitly along with the scalar flops.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= WIDTH'(DEFAULT_DIV);
            end
            mode_q    <= '0;
            armed_q   <= '1;
            div_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            mode_q    <= mode_d;
            armed_q   <= armed_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign armed   = armed_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// ----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Directed steps following the test plan, then randomized traffic, all checked
// against a phase-count reference model: each channel remembers how many
// counting cycles have elapsed since its last restart, and the outputs are
// derived from that count with modulo arithmetic.
// A second 3-channel instance covers out-of-range load_ch values, which a
// 4-channel instance cannot express on its 2-bit load_ch port.
// ----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int CH  = 4;
    localparam int W   = 28;
    localparam int DEF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          load;
    logic [1:0]    load_ch;
    logic [W-1:0]  load_div;
    logic          load_mode;
    logic          sync;
    logic [CH-1:0] div_out, tick, armed;

    logic          rst3;
    logic [2:0]    en3;
    logic          load3;
    logic [1:0]    load_ch3;
    logic [7:0]    load_div3;
    logic          load_mode3;
    logic          sync3;
    logic [2:0]    div_out3, tick3, armed3;

    always #5 clk = ~clk;

    clk_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_ch(load_ch),
        .load_div(load_div), .load_mode(load_mode), .sync(sync),
        .div_out(div_out), .tick(tick), .armed(armed)
    );

    clk_div_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(2)) u_dut3 (
        .clk(clk), .rst(rst3), .en(en3), .load(load3), .load_ch(load_ch3),
        .load_div(load_div3), .load_mode(load_mode3), .sync(sync3),
        .div_out(div_out3), .tick(tick3), .armed(armed3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_k   [CH];   // counting cycles since last restart
    int m_div [CH];
    bit m_mode[CH];
    bit m_arm [CH];
    bit m_tick[CH];
    bit m_do  [CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int deff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_edge(input bit r, input logic [CH-1:0] e, input bit ld,
                              input int ch, input int dv, input bit md, input bit sy);
        int  d;
        bit  prev;
        if (r) begin
            for (int i = 0; i < CH; i++) begin
                m_k[i] = 0; m_div[i] = DEF; m_mode[i] = 0;
                m_arm[i] = 1; m_tick[i] = 0; m_do[i] = 0;
            end
            return;
        end
        for (int i = 0; i < CH; i++) begin
            d         = deff(m_div[i]);
            prev      = m_arm[i];
            m_tick[i] = 0;
            if (e[i] && m_arm[i]) begin
                m_k[i]++;
                if (m_k[i] % d == 0) begin
                    m_tick[i] = 1;
                    if (m_mode[i]) m_arm[i] = 0;
                end
                m_do[i] = ((m_k[i] % d) >= d / 2);
            end
            if (sy) begin
                m_k[i] = 0; m_tick[i] = 0; m_arm[i] = prev;
                m_do[i] = (0 >= d / 2);
            end
            if (ld && ch == i && ch < CH) begin
                m_div[i] = dv; m_mode[i] = md; m_k[i] = 0;
                m_arm[i] = 1; m_tick[i] = 0;
                m_do[i] = (0 >= deff(dv) / 2);
            end
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare all outputs 1 time unit later.
    task automatic step(input bit r, input logic [CH-1:0] e, input bit ld,
                        input int ch, input int dv, input bit md, input bit sy);
        logic [CH-1:0] x_do, x_tick, x_arm;
        @(negedge clk);
        rst = r; en = e; load = ld; load_ch = ch[1:0];
        load_div = W'(dv); load_mode = md; sync = sy;
        @(posedge clk);
        model_edge(r, e, ld, ch, dv, md, sy);
        #1;
        for (int i = 0; i < CH; i++) begin
            x_do[i] = m_do[i]; x_tick[i] = m_tick[i]; x_arm[i] = m_arm[i];
        end
        check("div_out", 32'(div_out), 32'(x_do));
        check("tick",    32'(tick),    32'(x_tick));
        check("armed",   32'(armed),   32'(x_arm));
    endtask

    task automatic run(input logic [CH-1:0] e);
        step(0, e, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ticks;
        int first_j;
        bit r, ld, md, sy;
        logic [CH-1:0] e;
        int ch, dv;

        rst = 1; en = '0; load = 0; load_ch = '0; load_div = '0; load_mode = 0; sync = 0;
        rst3 = 1; en3 = '0; load3 = 0; load_ch3 = '0; load_div3 = '0; load_mode3 = 0; sync3 = 0;

        // 1: reset, then ch0 alone at DEFAULT_DIV
        step(1, 4'b0000, 0, 0, 0, 0, 0);
        check("rst_div_out", 32'(div_out), 32'h0);
        check("rst_armed",   32'(armed),   32'hF);
        run(4'b0001);
        check("t1_div_out_c1", 32'(div_out), 32'h1);
        run(4'b0001);
        check("t1_first_tick", 32'(tick), 32'h1);
        for (int j = 0; j < 4; j++) run(4'b0001);

        // 2: ch1 periodic divide-by-5
        step(0, 4'b0011, 1, 1, 5, 0, 0);
        ticks = 0;
        for (int j = 0; j < 20; j++) begin
            run(4'b0011);
            ticks += int'(tick[1]);
        end
        check("t2_ch1_ticks", 32'(ticks), 32'd4);

        // 3: ch2 one-shot divide-by-3
        step(0, 4'b0111, 1, 2, 3, 1, 0);
        ticks = 0; first_j = -1;
        for (int j = 0; j < 25; j++) begin
            run(4'b0111);
            if (tick[2]) begin
                ticks++;
                if (first_j < 0) first_j = j;
            end
        end
        check("t3_ch2_ticks",   32'(ticks),    32'd1);
        check("t3_tick_cycle",  32'(first_j),  32'd2);
        check("t3_disarmed",    32'(armed[2]), 32'd0);
        step(0, 4'b0000, 1, 2, 3, 1, 0);
        check("t3_rearmed",     32'(armed[2]), 32'd1);

        // 4: ch0 /4 and ch1 /6 out of phase, then sync
        step(0, 4'b0011, 1, 0, 4, 0, 0);
        for (int j = 0; j < 3; j++) run(4'b0011);
        step(0, 4'b0011, 1, 1, 6, 0, 0);
        for (int j = 0; j < 2; j++) run(4'b0011);
        step(0, 4'b0011, 0, 0, 0, 0, 1);
        check("t4_sync_div_out", 32'(div_out[1:0]), 32'd0);
        ticks = 0;
        for (int j = 0; j < 11; j++) begin
            run(4'b0011);
            if (tick[1:0] == 2'b11) ticks++;
        end
        check("t4_no_early_coincide", 32'(ticks), 32'd0);
        run(4'b0011);
        check("t4_coincide_12", 32'(tick[1:0]), 32'd3);

        // 5: ch3 with div 0 and div 1
        step(0, 4'b1000, 1, 3, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            run(4'b1000);
            check("t5_div0_out_tick", 32'({div_out[3], tick[3]}), 32'd3);
        end
        step(0, 4'b1000, 1, 3, 1, 0, 0);
        check("t5_div1_load_out", 32'(div_out[3]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            run(4'b1000);
            check("t5_div1_out_tick", 32'({div_out[3], tick[3]}), 32'd3);
        end

        // 6: reset mid-count with a load pending
        step(0, 4'b0010, 1, 1, 6, 0, 0);
        for (int j = 0; j < 3; j++) run(4'b0010);
        step(1, 4'b0010, 1, 1, 9, 1, 1);
        check("t6_rst_div_out", 32'(div_out), 32'h0);
        check("t6_rst_tick",    32'(tick),    32'h0);
        check("t6_rst_armed",   32'(armed),   32'hF);
        run(4'b0010);
        run(4'b0010);
        check("t6_default_div_tick", 32'(tick[1]), 32'd1);

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = CH'($urandom);
            ld = ($urandom_range(0, 9) == 0);
            ch = int'($urandom_range(0, 3));
            dv = int'($urandom_range(0, 7));
            md = 1'($urandom_range(0, 1));
            sy = ($urandom_range(0, 19) == 0);
            step(r, e, ld, ch, dv, md, sy);
        end
        step(0, 4'b0000, 0, 0, 0, 0, 0);

        // Out-of-range load on the 3-channel instance is ignored
        @(negedge clk);
        rst3 = 1;
        @(negedge clk);
        rst3 = 0; en3 = 3'b001; load3 = 1; load_ch3 = 2'd3; load_div3 = 8'd1; load_mode3 = 1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("oor_div_out", 32'(div_out3), (k % 2 == 1) ? 32'd1 : 32'd0);
            check("oor_tick",    32'(tick3),    (k % 2 == 0) ? 32'd1 : 32'd0);
            check("oor_armed",   32'(armed3),   32'd7);
            @(negedge clk);
            load3 = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
